// File: rtl/cs_window_sched_pkg.sv
// Shared types and sizes for the CS approximate-average window scheduler.
package cs_pkg;

  localparam int WIN  = 9;
  localparam int DW   = 8;
  localparam int OW   = 10;
  localparam int SUMW = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } cs_state_t;

endpackage

// File: rtl/cs_window_sched_scan.sv
// Shared compare unit: qualifies one window entry (9*x <= sum) and folds it into the running best.
module cs_scan_unit
  import cs_pkg::*;
(
  input  logic [DW-1:0]   x_i,
  input  logic [SUMW-1:0] sum_i,
  input  logic [DW-1:0]   best_i,
  output logic            qualify_o,
  output logic [DW-1:0]   best_nxt_o
);

  logic [SUMW-1:0] nine_x_s;

  // 9*x as 8x + x keeps the average test free of a divider
  always_comb begin
    nine_x_s   = {1'b0, x_i, 3'b000} + {4'b0000, x_i};
    qualify_o  = (nine_x_s <= sum_i);
    if (qualify_o && (x_i > best_i)) begin
      best_nxt_o = x_i;
    end else begin
      best_nxt_o = best_i;
    end
  end

endmodule

// File: rtl/cs_window_sched.sv
// 9-sample window with running sum and a serial max-below-average scan.
// Optional build macro CS_EARLY_OUT_EN: scan and emit on every accepted sample, even while filling.
module cs_window_sched
  import cs_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_x,
  output logic          in_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_y,
  input  logic          out_ready,
  output logic          win_full,
  output logic          busy
);

`ifdef CS_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  cs_state_t       state_q, state_d;
  logic [DW-1:0]   buf_q [WIN];
  logic [SUMW-1:0] sum_q, sum_d;
  logic [3:0]      wp_q, wp_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [DW-1:0]   best_q, best_d;
  logic [OW-1:0]   y_q, y_d;

  logic            accept_s;
  logic            qualify_s;
  logic [DW-1:0]   best_nxt_s;
  logic [SUMW-1:0] nine_best_s;
  logic [12:0]     total_s;

  assign in_ready  = (state_q == IDLE) & ~reset;
  assign accept_s  = in_valid & in_ready;
  assign out_valid = (state_q == OUT);
  assign out_y     = y_q;
  assign win_full  = (cnt_q == 4'd9);
  assign busy      = (state_q != IDLE);

  cs_scan_unit u_scan (
    .x_i        (buf_q[idx_q]),
    .sum_i      (sum_q),
    .best_i     (best_q),
    .qualify_o  (qualify_s),
    .best_nxt_o (best_nxt_s)
  );

  assign nine_best_s = {1'b0, best_q, 3'b000} + {4'b0000, best_q};
  assign total_s     = {1'b0, sum_q} + {1'b0, nine_best_s};

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sum_q   <= 12'd0;
      wp_q    <= 4'd0;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      best_q  <= 8'd0;
      y_q     <= 10'd0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      y_q     <= y_d;
    end
  end

  // Window buffer: overwrite the oldest entry on each accepted sample
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) begin
        buf_q[i] <= 8'd0;
      end
    end else if (accept_s) begin
      buf_q[wp_q] <= in_x;
    end else begin
      buf_q[wp_q] <= buf_q[wp_q];
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    best_d  = best_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sum_d = sum_q - {4'b0000, buf_q[wp_q]} + {4'b0000, in_x};
          wp_d  = (wp_q == 4'd8) ? 4'd0 : (wp_q + 4'd1);
          cnt_d = (cnt_q == 4'd9) ? 4'd9 : (cnt_q + 4'd1);
          if ((cnt_d == 4'd9) || EARLY_OUT) begin
            state_d = SCAN;
            idx_d   = 4'd0;
            best_d  = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        best_d = best_nxt_s;
        if (idx_q == 4'd8) begin
          idx_d   = 4'd0;
          state_d = CALC;
        end else begin
          idx_d   = idx_q + 4'd1;
        end
      end
      CALC: begin
        y_d     = total_s[12:3];
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cs_window_sched.sv
// Randomised self-checking bench for cs_window_sched against a queue-based window model.
module tb_cs_window_sched;

`ifdef CS_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_x;
  logic       in_ready;
  logic       out_valid;
  logic [9:0] out_y;
  logic       out_ready;
  logic       win_full;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int mwin[$];
  int mcnt;

  cs_window_sched dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_y     (out_y),
    .out_ready (out_ready),
    .win_full  (win_full),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic void model_reset();
    mwin = {};
    for (int i = 0; i < 9; i++) mwin.push_back(0);
    mcnt = 0;
  endfunction

  // Window = last nine samples (zeros before fill); result from average rule directly
  task automatic model_push(input int x, output bit exp_out, output int exp_y);
    int s;
    int b;
    void'(mwin.pop_front());
    mwin.push_back(x);
    if (mcnt < 9) mcnt++;
    s = 0;
    foreach (mwin[i]) s += mwin[i];
    b = 0;
    foreach (mwin[i]) if (mwin[i] * 9 <= s && mwin[i] > b) b = mwin[i];
    exp_y   = (s + 9 * b) / 8;
    exp_out = (mcnt == 9) || EARLY;
  endtask

  task automatic send(input logic [7:0] x, input int hold, output int y_obs);
    bit exp_out;
    int exp_y;
    int lat;
    bit seen;
    y_obs = -1;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL in_ready_wait: got in_ready=%b, required 1", in_ready);
      return;
    end
    in_valid  = 1'b1;
    in_x      = x;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x     = 8'($urandom);
    model_push(int'(x), exp_out, exp_y);
    if (exp_out) begin
      lat = 0;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          lat = c;
          break;
        end
      end
      checks++;
      if (lat != 11) begin
        errors++;
        $display("FAIL latency: got %0d cycles, required 11", lat);
      end
      checks++;
      if (out_y !== 10'(exp_y)) begin
        errors++;
        $display("FAIL out_y: sample %0d got %0d, required %0d", x, out_y, exp_y);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_during_out: got %b, required 0", in_ready);
      end
      y_obs = int'(out_y);
      if (hold > 0) begin
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out_y !== 10'(y_obs) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold: got valid=%b y=%0d rdy=%b, required 1 %0d 0", out_valid, out_y, in_ready, y_obs);
          end
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_handshake: got valid=%b rdy=%b, required 0 1", out_valid, in_ready);
      end
    end else begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_no_output: got valid=%b busy=%b rdy=%b, required 0 0 1", out_valid, busy, in_ready);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_y !== 10'd0 || win_full !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b y=%0d wf=%b busy=%b, required 1 0 0 0 0",
               in_ready, out_valid, out_y, win_full, busy);
    end
  endtask

  task automatic test_fill();
    int vals[9] = '{12, 15, 9, 20, 31, 3, 17, 11, 6};
    int y;
    for (int i = 0; i < 8; i++) send(8'(vals[i]), 0, y);
    checks++;
    if (win_full !== 1'b0) begin
      errors++;
      $display("FAIL win_full_early: got %b, required 0", win_full);
    end
    send(8'(vals[8]), 0, y);
    checks++;
    if (y != 29) begin
      errors++;
      $display("FAIL fill_result: got %0d, required 29", y);
    end
    checks++;
    if (win_full !== 1'b1) begin
      errors++;
      $display("FAIL win_full: got %b, required 1", win_full);
    end
    send(8'd100, 0, y);
    checks++;
    if (y != 49) begin
      errors++;
      $display("FAIL slide_result: got %0d, required 49", y);
    end
  endtask

  task automatic test_extremes();
    int y;
    for (int i = 0; i < 9; i++) send(8'd255, 0, y);
    checks++;
    if (y != 573) begin
      errors++;
      $display("FAIL all_255: got %0d, required 573", y);
    end
    for (int i = 0; i < 9; i++) send(8'd0, 0, y);
    checks++;
    if (y != 0) begin
      errors++;
      $display("FAIL all_zero: got %0d, required 0", y);
    end
  endtask

  task automatic test_stall();
    int y;
    send(8'd77, 5, y);
  endtask

  task automatic test_reset_mid_scan();
    int y;
    in_valid  = 1'b1;
    in_x      = 8'd42;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_scan_busy: got %b, required 1", busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || win_full !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_scan: got v=%b wf=%b busy=%b rdy=%b, required 0 0 0 1",
               out_valid, win_full, busy, in_ready);
    end
    for (int i = 0; i < 9; i++) send(8'($urandom_range(0, 255)), 0, y);
  endtask

  task automatic test_early();
    int y;
    test_reset();
    send(8'd90, 0, y);
    checks++;
    if (y != 11) begin
      errors++;
      $display("FAIL early_first: got %0d, required 11", y);
    end
  endtask

  task automatic test_random();
    int y;
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, y);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = 8'd0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_fill();
    test_extremes();
    test_stall();
    test_reset_mid_scan();
    test_random();
    if (EARLY) test_early();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
